// File: rtl/pe_mac_stream.sv
// Systolic-array PE: registered A/B forwarding, framed multiply-accumulate, one-entry result buffer.
// Build option: define PE_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module pe_mac_stream #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned SIGNED = 0
) (
    input  logic              i_clk,
    input  logic              i_arst,
    input  logic [DATA_W-1:0] i_a,
    input  logic              i_a_valid,
    input  logic              i_a_first,
    input  logic              i_a_last,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_b_valid,
    output logic [DATA_W-1:0] o_a,
    output logic              o_a_valid,
    output logic              o_a_first,
    output logic              o_a_last,
    output logic [DATA_W-1:0] o_b,
    output logic              o_b_valid,
    output logic [ACC_W-1:0]  o_y,
    output logic              o_y_valid,
    input  logic              i_y_ready,
    output logic              o_y_ovf,
    output logic              o_overrun
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned EXT_W  = ACC_W + 1 - PROD_W;

    typedef enum logic {
        StIdle,
        StAcc
    } state_t;

    state_t state_q, state_d;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] a_q, b_q;
    logic              a_valid_q, a_first_q, a_last_q, b_valid_q;

    logic [ACC_W-1:0]  y_q;
    logic              y_valid_q, y_ovf_q, overrun_q;

    logic              fire;
    logic              is_signed;
    logic [PROD_W-1:0] a_ext, b_ext, prod;
    logic [ACC_W:0]    prod_ext, acc_ext, sum;
    logic              ovf_now;
    logic [ACC_W-1:0]  add_val;
    logic [ACC_W-1:0]  frame_acc;
    logic              frame_ovf;
    logic              complete;
    logic [ACC_W-1:0]  res_val;
    logic              res_ovf;

    assign fire      = i_a_valid & i_b_valid;
    assign is_signed = (SIGNED != 0);

    // Sign/zero extend operands first so the low PROD_W bits of one multiplier
    // are correct for both signed and unsigned builds.
    assign a_ext    = {{DATA_W{is_signed & i_a[DATA_W-1]}}, i_a};
    assign b_ext    = {{DATA_W{is_signed & i_b[DATA_W-1]}}, i_b};
    assign prod     = a_ext * b_ext;
    assign prod_ext = {{EXT_W{is_signed & prod[PROD_W-1]}}, prod};
    assign acc_ext  = {is_signed & acc_q[ACC_W-1], acc_q};
    assign sum      = acc_ext + prod_ext;
    assign ovf_now  = is_signed ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];

`ifdef PE_SATURATE_EN
    logic [ACC_W-1:0] sat_val;

    // In a signed sum the extra top bit carries the true sign, i.e. the overflow direction.
    always_comb begin
        sat_val = '1;
        if (is_signed) begin
            sat_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    // Once clamped, the accumulator holds for the rest of the frame.
    always_comb begin
        add_val = sum[ACC_W-1:0];
        if (ovf_q) begin
            add_val = acc_q;
        end else if (ovf_now) begin
            add_val = sat_val;
        end
    end
`else
    always_comb begin
        add_val = sum[ACC_W-1:0];
    end
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        frame_acc = acc_q;
        frame_ovf = ovf_q;
        complete  = 1'b0;
        res_val   = acc_q;
        res_ovf   = ovf_q;

        if (fire) begin
            if ((state_q == StIdle) || i_a_first) begin
                frame_acc = prod_ext[ACC_W-1:0];
                frame_ovf = 1'b0;
            end else begin
                frame_acc = add_val;
                frame_ovf = ovf_q | ovf_now;
            end

            if (i_a_last) begin
                complete = 1'b1;
                res_val  = frame_acc;
                res_ovf  = frame_ovf;
                acc_d    = '0;
                ovf_d    = 1'b0;
                state_d  = StIdle;
            end else begin
                acc_d    = frame_acc;
                ovf_d    = frame_ovf;
                state_d  = StAcc;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    // Forwarding path is independent of the MAC and of result backpressure.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            a_q       <= '0;
            a_valid_q <= 1'b0;
            a_first_q <= 1'b0;
            a_last_q  <= 1'b0;
            b_q       <= '0;
            b_valid_q <= 1'b0;
        end else begin
            if (i_a_valid) begin
                a_q <= i_a;
            end
            if (i_b_valid) begin
                b_q <= i_b;
            end
            a_valid_q <= i_a_valid;
            a_first_q <= i_a_first;
            a_last_q  <= i_a_last;
            b_valid_q <= i_b_valid;
        end
    end

    // Completion has priority over a read so a same-cycle read and reload keeps valid high.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_ovf_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= complete & y_valid_q & ~i_y_ready;
            if (complete) begin
                y_q       <= res_val;
                y_ovf_q   <= res_ovf;
                y_valid_q <= 1'b1;
            end else if (y_valid_q & i_y_ready) begin
                y_valid_q <= 1'b0;
            end
        end
    end

    assign o_a       = a_q;
    assign o_a_valid = a_valid_q;
    assign o_a_first = a_first_q;
    assign o_a_last  = a_last_q;
    assign o_b       = b_q;
    assign o_b_valid = b_valid_q;
    assign o_y       = y_q;
    assign o_y_valid = y_valid_q;
    assign o_y_ovf   = y_ovf_q;
    assign o_overrun = overrun_q;

endmodule
